rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that turns a level request vector into a registered one-hot grant with tenure handshake.
- Sits directly upstream of the one-hot-to-binary index encoder. That encoder consumes `grant` and produces the granted index for the bus/peripheral mux.
- Guarantees `grant` is at most one-hot, so the downstream encoder's output is always unambiguous.

Parameters:
- REQ_WIDTH, 16, number of requesters; legal range 2..32.
- TIMEOUT_CYCLES, 255, maximum tenure in cycles. Used only when ARB_TIMEOUT_EN is defined; must be ≥1 and fit in 16 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  REQ_WIDTH  level requests; bit i = requester i
- done  input  1  one-cycle pulse from the current owner/consumer ending its tenure
- grant  output  REQ_WIDTH  registered one-hot grant; all-zero when idle
- grant_valid  output  1  registered; equals |grant
- grant_new  output  1  registered one-cycle pulse in the first cycle of each new tenure
- timeout  output  1  exists only with ARB_TIMEOUT_EN; one-cycle pulse on forced release

Behaviour:
- Reset values (rst high at an edge):
  - grant=0, grant_valid=0, grant_new=0, timeout=0.
  - State=IDLE; last-owner pointer=REQ_WIDTH-1, so bit 0 has highest priority after reset.
- States:
  - IDLE: no owner.
  - BUSY: grant holds exactly one bit.
- Arbitration function:
  - Search order is (last+1), (last+2), … wrapping modulo REQ_WIDTH, ending at last itself.
  - The first set bit of req in that order wins.
  - Combinational, single cycle, no priority inversion at the wrap.
- IDLE:
  - If |req=1 at edge t, the edge t sets grant=winner, grant_valid=1, grant_new=1, last=winner index, state=BUSY.
  - Latency from req to grant is one cycle.
  - If req=0, stay IDLE.
- BUSY, tenure end: tenure ends at edge t when any of these holds:
  - done=1;
  - req[owner]=0 (requester withdrew);
  - timeout fires (optional feature).
- BUSY, on tenure end:
  - Re-arbitrate in the same edge using req masked with the owner's bit cleared.
  - If a winner exists, grant moves to it at edge t: zero-bubble handoff, grant_new=1, last updated.
  - Otherwise grant=0, grant_valid=0, state=IDLE.
  - The releasing requester cannot win back-to-back, even if its req stays high. It may win again at the next arbitration.
- BUSY with no end condition: grant stable, grant_new=0.
- done in IDLE is ignored.
- done and req[owner] falling in the same cycle count as a single release.
- Requests arriving or leaving for non-owners during BUSY have no effect until the next arbitration.
- Single requester:
  - req=only bit k, held high, with repeated done pulses gives alternating grant=k / idle cycle / grant=k.
  - The masked re-arbitration finds nothing, so the block returns to IDLE and re-grants on the next edge.
- rst mid-tenure: grant drops to 0 at that edge and the pointer returns to REQ_WIDTH-1. No release pulse or timeout is emitted.
- Invariant: $countones(grant)≤1 every cycle; grant_valid==|grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit tenure counter clears on every new grant and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES-1 with no other end condition, the tenure is force-ended at that edge using the normal release/re-arbitration rules, and timeout pulses high for one cycle.
  - A tenure therefore lasts at most TIMEOUT_CYCLES cycles.
  - If done arrives in the same cycle as expiry, done takes precedence and timeout stays 0.
- When undefined:
  - No counter and no timeout port.
  - Tenure is unbounded.

Test Plan (REQ_WIDTH=4 unless stated):
- Reset then req=4'b1010 → the next edge gives grant=0010, grant_valid=1, grant_new=1. The following cycle grant_new=0 and grant stays stable until done.
- req=4'b1111 held, done pulsed every 3rd cycle → grant sequence 0001,0010,0100,1000,0001 with no idle cycle between tenures.
- Owner 0010 drops req[1] with req[3]=1 → grant=1000 at the next edge. With req[3]=0 instead → grant=0000 and IDLE.
- Single requester req=0100 held, done pulsed → grant 0100, then 0000 for one cycle, then 0100 again. grant_new pulses on each grant.
- rst asserted while grant=1000 → grant=0000 at that edge. Afterwards req=1001 → grant=0001 (pointer reset).
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=5, req=0011 held, no done → grant 0001 for 5 cycles, timeout pulse, then grant 0010. Repeat with done in the 5th cycle → timeout=0.

Source files
------------

// File: rtl/rr_grant_arbiter_if.sv
// rtl/rr_grant_arbiter_if.sv - request/grant handshake bundle for rr_grant_arbiter
// The timeout member exists only when ARB_TIMEOUT_EN is defined.
interface rr_grant_arbiter_if #(
  parameter int REQ_WIDTH = 16
);
  logic [REQ_WIDTH-1:0] req;
  logic                 done;
  logic [REQ_WIDTH-1:0] grant;
  logic                 grant_valid;
  logic                 grant_new;
`ifdef ARB_TIMEOUT_EN
  logic                 timeout;
`endif

  // master: the arbiter; slave: the requesters / tenure consumer
  modport master (
    input  req,
    input  done,
`ifdef ARB_TIMEOUT_EN
    output timeout,
`endif
    output grant,
    output grant_valid,
    output grant_new
  );

  modport slave (
    output req,
    output done,
`ifdef ARB_TIMEOUT_EN
    input  timeout,
`endif
    input  grant,
    input  grant_valid,
    input  grant_new
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with registered one-hot grant and tenure handshake
// Optional tenure limit enabled by defining ARB_TIMEOUT_EN.
module rr_grant_arbiter #(
  parameter int REQ_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  rr_grant_arbiter_if.master  bus
);

  localparam int IDX_W = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1;
  localparam int PW    = IDX_W + 1;

  if (REQ_WIDTH < 2 || REQ_WIDTH > 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("rr_grant_arbiter: illegal REQ_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [REQ_WIDTH-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 valid_q, valid_d;
  logic                 new_q, new_d;

  logic                 owner_req;
  logic                 expire;
  logic                 tenure_end;
  logic [REQ_WIDTH-1:0] arb_req;
  logic [REQ_WIDTH-1:0] arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_found;
  logic [PW-1:0]        pos;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
`endif

  // Winner search starts just after the last owner and wraps, so the last
  // owner is checked last; in BUSY the owner is masked out entirely.
  always_comb begin
    owner_req = |(bus.req & grant_q);
    arb_req   = (state_q == BUSY) ? (bus.req & ~grant_q) : bus.req;
    arb_oh    = '0;
    arb_idx   = last_q;
    arb_found = 1'b0;
    pos       = '0;
    for (int i = 1; i <= REQ_WIDTH; i++) begin
      pos = {1'b0, last_q} + PW'(i);
      if (pos >= PW'(REQ_WIDTH)) begin
        pos = pos - PW'(REQ_WIDTH);
      end
      if (!arb_found && arb_req[pos[IDX_W-1:0]]) begin
        arb_found                = 1'b1;
        arb_idx                  = pos[IDX_W-1:0];
        arb_oh[pos[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(REQ_WIDTH - 1);
      valid_q <= 1'b0;
      new_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      new_q   <= new_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    new_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    expire  = (state_q == BUSY) && (cnt_q == TMO_LAST);
    cnt_d   = (state_q == BUSY) ? cnt_q + 16'd1 : 16'd0;
    // done or a withdrawal already ends the tenure; only a pure expiry is a timeout
    tmo_d   = expire && !bus.done && owner_req;
`else
    expire  = 1'b0;
`endif
    tenure_end = (state_q == BUSY) && (bus.done || !owner_req || expire);

    if (state_q == IDLE || tenure_end) begin
      if (arb_found) begin
        state_d = BUSY;
        grant_d = arb_oh;
        last_d  = arb_idx;
        new_d   = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
`ifdef ARB_TIMEOUT_EN
      cnt_d = 16'd0;
`endif
    end
    valid_d = |grant_d;
  end

  always_comb begin
    bus.grant       = grant_q;
    bus.grant_valid = valid_q;
    bus.grant_new   = new_q;
`ifdef ARB_TIMEOUT_EN
    bus.timeout     = tmo_q;
`endif
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter (REQ_WIDTH=4)
module tb_rr_grant_arbiter;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;
  logic mon_en;

  rr_grant_arbiter_if #(.REQ_WIDTH(4)) ifc ();

  rr_grant_arbiter #(.REQ_WIDTH(4), .TIMEOUT_CYCLES(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk_cnt++;
      if ($countones(ifc.grant) > 1 || ifc.grant_valid !== (|ifc.grant))
        $display("FAIL invariant grant=%b grant_valid=%b", ifc.grant, ifc.grant_valid);
      else
        pass_cnt++;
    end
  end

  task automatic test_reset();
    rst = 1'b1; ifc.req = 4'b0000; ifc.done = 1'b0;
    step(); step();
    chk_cnt++; if (ifc.grant !== 4'b0000) $display("FAIL reset_grant got=%b want=0000", ifc.grant); else pass_cnt++;
    chk_cnt++; if (ifc.grant_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", ifc.grant_valid); else pass_cnt++;
    chk_cnt++; if (ifc.grant_new !== 1'b0) $display("FAIL reset_new got=%b want=0", ifc.grant_new); else pass_cnt++;
`ifdef ARB_TIMEOUT_EN
    chk_cnt++; if (ifc.timeout !== 1'b0) $display("FAIL reset_timeout got=%b want=0", ifc.timeout); else pass_cnt++;
`endif
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_first_grant();
    ifc.req = 4'b1010; step();
    chk_cnt++; if (ifc.grant !== 4'b0010) $display("FAIL first_grant got=%b want=0010", ifc.grant); else pass_cnt++;
    chk_cnt++; if (ifc.grant_valid !== 1'b1) $display("FAIL first_valid got=%b want=1", ifc.grant_valid); else pass_cnt++;
    chk_cnt++; if (ifc.grant_new !== 1'b1) $display("FAIL first_new got=%b want=1", ifc.grant_new); else pass_cnt++;
    step();
    chk_cnt++; if (ifc.grant !== 4'b0010) $display("FAIL first_hold got=%b want=0010", ifc.grant); else pass_cnt++;
    chk_cnt++; if (ifc.grant_new !== 1'b0) $display("FAIL first_new_drop got=%b want=0", ifc.grant_new); else pass_cnt++;
    step();
    chk_cnt++; if (ifc.grant !== 4'b0010) $display("FAIL first_hold2 got=%b want=0010", ifc.grant); else pass_cnt++;
    ifc.done = 1'b1; step(); ifc.done = 1'b0;
    chk_cnt++; if (ifc.grant !== 4'b1000) $display("FAIL first_handoff got=%b want=1000", ifc.grant); else pass_cnt++;
    chk_cnt++; if (ifc.grant_new !== 1'b1) $display("FAIL first_handoff_new got=%b want=1", ifc.grant_new); else pass_cnt++;
    ifc.req = 4'b0000; step();
    chk_cnt++; if (ifc.grant !== 4'b0000) $display("FAIL first_idle got=%b want=0000", ifc.grant); else pass_cnt++;
    chk_cnt++; if (ifc.grant_valid !== 1'b0) $display("FAIL first_idle_valid got=%b want=0", ifc.grant_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] rot_exp [4];
    logic [3:0] prev;
    rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ifc.req = 4'b1111; step();
    chk_cnt++; if (ifc.grant !== 4'b0001) $display("FAIL rot_start got=%b want=0001", ifc.grant); else pass_cnt++;
    prev = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_cnt++; if (ifc.grant !== prev || ifc.grant_new !== 1'b0)
        $display("FAIL rot_hold[%0d] got=%b/%b want=%b/0", k, ifc.grant, ifc.grant_new, prev); else pass_cnt++;
      step();
      ifc.done = 1'b1; step(); ifc.done = 1'b0;
      chk_cnt++; if (ifc.grant !== rot_exp[k] || ifc.grant_new !== 1'b1)
        $display("FAIL rot_next[%0d] got=%b/%b want=%b/1", k, ifc.grant, ifc.grant_new, rot_exp[k]); else pass_cnt++;
      prev = rot_exp[k];
    end
    ifc.req = 4'b0000; step();
    chk_cnt++; if (ifc.grant !== 4'b0000) $display("FAIL rot_idle got=%b want=0000", ifc.grant); else pass_cnt++;
  endtask

  task automatic test_withdraw();
    ifc.done = 1'b1; step(); ifc.done = 1'b0;
    chk_cnt++; if (ifc.grant !== 4'b0000 || ifc.grant_new !== 1'b0)
      $display("FAIL idle_done got=%b/%b want=0000/0", ifc.grant, ifc.grant_new); else pass_cnt++;
    ifc.req = 4'b0010; step();
    chk_cnt++; if (ifc.grant !== 4'b0010) $display("FAIL wd_grant got=%b want=0010", ifc.grant); else pass_cnt++;
    ifc.req = 4'b1010; step();
    chk_cnt++; if (ifc.grant !== 4'b0010 || ifc.grant_new !== 1'b0)
      $display("FAIL wd_nonowner got=%b/%b want=0010/0", ifc.grant, ifc.grant_new); else pass_cnt++;
    ifc.req = 4'b1000; step();
    chk_cnt++; if (ifc.grant !== 4'b1000 || ifc.grant_new !== 1'b1)
      $display("FAIL wd_handoff got=%b/%b want=1000/1", ifc.grant, ifc.grant_new); else pass_cnt++;
    ifc.req = 4'b0000; step();
    ifc.req = 4'b0010; step();
    chk_cnt++; if (ifc.grant !== 4'b0010) $display("FAIL wd_grant2 got=%b want=0010", ifc.grant); else pass_cnt++;
    ifc.req = 4'b0000; step();
    chk_cnt++; if (ifc.grant !== 4'b0000 || ifc.grant_valid !== 1'b0)
      $display("FAIL wd_to_idle got=%b/%b want=0000/0", ifc.grant, ifc.grant_valid); else pass_cnt++;
    ifc.req = 4'b0010; step();
    ifc.req = 4'b1000; ifc.done = 1'b1; step(); ifc.done = 1'b0;
    chk_cnt++; if (ifc.grant !== 4'b1000 || ifc.grant_new !== 1'b1)
      $display("FAIL wd_done_and_drop got=%b/%b want=1000/1", ifc.grant, ifc.grant_new); else pass_cnt++;
    step();
    chk_cnt++; if (ifc.grant !== 4'b1000 || ifc.grant_new !== 1'b0)
      $display("FAIL wd_single_release got=%b/%b want=1000/0", ifc.grant, ifc.grant_new); else pass_cnt++;
    ifc.req = 4'b0000; step();
  endtask

  task automatic test_single();
    ifc.req = 4'b0100; step();
    chk_cnt++; if (ifc.grant !== 4'b0100 || ifc.grant_new !== 1'b1)
      $display("FAIL single_grant got=%b/%b want=0100/1", ifc.grant, ifc.grant_new); else pass_cnt++;
    step();
    ifc.done = 1'b1; step(); ifc.done = 1'b0;
    chk_cnt++; if (ifc.grant !== 4'b0000 || ifc.grant_valid !== 1'b0 || ifc.grant_new !== 1'b0)
      $display("FAIL single_gap got=%b/%b/%b want=0000/0/0", ifc.grant, ifc.grant_valid, ifc.grant_new); else pass_cnt++;
    step();
    chk_cnt++; if (ifc.grant !== 4'b0100 || ifc.grant_new !== 1'b1)
      $display("FAIL single_regrant got=%b/%b want=0100/1", ifc.grant, ifc.grant_new); else pass_cnt++;
    ifc.req = 4'b0000; step();
  endtask

  task automatic test_reset_mid();
    ifc.req = 4'b1000; step();
    chk_cnt++; if (ifc.grant !== 4'b1000) $display("FAIL rstmid_pre got=%b want=1000", ifc.grant); else pass_cnt++;
    rst = 1'b1; step(); rst = 1'b0;
    chk_cnt++; if (ifc.grant !== 4'b0000 || ifc.grant_valid !== 1'b0 || ifc.grant_new !== 1'b0)
      $display("FAIL rstmid_drop got=%b/%b/%b want=0000/0/0", ifc.grant, ifc.grant_valid, ifc.grant_new); else pass_cnt++;
    ifc.req = 4'b1001; step();
    chk_cnt++; if (ifc.grant !== 4'b0001) $display("FAIL rstmid_after got=%b want=0001", ifc.grant); else pass_cnt++;
    ifc.req = 4'b0000; step();
    ifc.req = 4'b0010; step();
    rst = 1'b1; step(); rst = 1'b0;
    ifc.req = 4'b0110; step();
    chk_cnt++; if (ifc.grant !== 4'b0010) $display("FAIL rstmid_pointer got=%b want=0010", ifc.grant); else pass_cnt++;
    ifc.req = 4'b0000; step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    ifc.req = 4'b0011; step();
    chk_cnt++; if (ifc.grant !== 4'b0001 || ifc.timeout !== 1'b0)
      $display("FAIL tmo_start got=%b/%b want=0001/0", ifc.grant, ifc.timeout); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_cnt++; if (ifc.grant !== 4'b0001 || ifc.timeout !== 1'b0)
        $display("FAIL tmo_hold[%0d] got=%b/%b want=0001/0", k, ifc.grant, ifc.timeout); else pass_cnt++;
    end
    step();
    chk_cnt++; if (ifc.grant !== 4'b0010 || ifc.timeout !== 1'b1 || ifc.grant_new !== 1'b1)
      $display("FAIL tmo_fire got=%b/%b/%b want=0010/1/1", ifc.grant, ifc.timeout, ifc.grant_new); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_cnt++; if (ifc.grant !== 4'b0010 || ifc.timeout !== 1'b0)
        $display("FAIL tmo_hold2[%0d] got=%b/%b want=0010/0", k, ifc.grant, ifc.timeout); else pass_cnt++;
    end
    ifc.done = 1'b1; step(); ifc.done = 1'b0;
    chk_cnt++; if (ifc.grant !== 4'b0001 || ifc.timeout !== 1'b0 || ifc.grant_new !== 1'b1)
      $display("FAIL tmo_done_wins got=%b/%b/%b want=0001/0/1", ifc.grant, ifc.timeout, ifc.grant_new); else pass_cnt++;
    ifc.req = 4'b0000; step();
  endtask
`endif

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    ifc.req  = 4'b0000;
    ifc.done = 1'b0;
    test_reset();
    test_first_grant();
    test_back_to_back();
    test_withdraw();
    test_single();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
